// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Snapshots NUM_DIGITS packed BCD counts from the counter bank and scans
//   them onto an active-low, common-anode, time-multiplexed 7-segment display.
//   Each digit is driven for REFRESH_DIV cycles, followed by a one-cycle dark
//   gap so the anodes never overlap. Leading zeros can be blanked. Codes 10-15
//   are shown blank and raise `invalid`.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   digits_in    packed BCD, digit 0 at [3:0]
//   dp_in        per-digit decimal-point request, 1 = lit
//   load_strobe  1-cycle pulse, copies digits_in/dp_in into the shadow regs
//   enable       1 = scan, 0 = dark (index/prescaler held)
//   seg_n        {g,f,e,d,c,b,a}, active-low
//   dp_n         decimal point, active-low
//   an_n         anode selects, active-low, one-hot-low while driving
//   invalid      1 while any shadow digit > 9

// Per-digit segment decoder with blank override.
module bcd_scan_digit (
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);
  always_comb begin
    seg_n_o = 7'h7F;
    if (!blank_i) begin
      unique case (bcd_i)
        4'd0:    seg_n_o = 7'h40;
        4'd1:    seg_n_o = 7'h79;
        4'd2:    seg_n_o = 7'h24;
        4'd3:    seg_n_o = 7'h30;
        4'd4:    seg_n_o = 7'h19;
        4'd5:    seg_n_o = 7'h12;
        4'd6:    seg_n_o = 7'h02;
        4'd7:    seg_n_o = 7'h78;
        4'd8:    seg_n_o = 7'h00;
        4'd9:    seg_n_o = 7'h10;
        default: seg_n_o = 7'h7F;
      endcase
    end
  end
endmodule

module bcd_scan_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load_strobe,
  input  logic                      enable,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      invalid
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_e;

  state_e                       state_q, state_d;
  logic [PW-1:0]                presc_q, presc_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   dig_q;
  logic [NUM_DIGITS-1:0]        dpr_q;
  logic                         invalid_q;
  logic [6:0]                   seg_n_q, seg_n_d;
  logic                         dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]        an_n_q, an_n_d;

  logic [NUM_DIGITS-1:0]        lz_blank;
  logic [NUM_DIGITS-1:0]        dig_bad;
  logic [NUM_DIGITS-1:0][6:0]   lane_seg;
  logic                         zero_run;
  logic                         drive_entry;

  // Leading-zero mask: walk down from the top digit while everything seen
  // so far is zero. Digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (dig_q[i] == 4'd0);
      lz_blank[i] = zero_run && (i > 0) && (BLANK_LEADING != 0);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
      assign dig_bad[g] = (dig_q[g] > 4'd9);
      bcd_scan_digit u_dec (
        .bcd_i   (dig_q[g]),
        .blank_i (lz_blank[g]),
        .seg_n_o (lane_seg[g])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; enable low wins from any state.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = DRIVE;
        DRIVE:   if (presc_q == PRESC_LAST) state_d = GAP;
        GAP:     state_d = DRIVE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign drive_entry = (state_d == DRIVE) && (state_q != DRIVE);

  // Output logic. The displayed digit is latched on DRIVE entry and held for
  // the whole slot, so a mid-slot strobe never tears the current digit.
  always_comb begin
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    if (state_d == DRIVE) begin
      if (drive_entry) begin
        seg_n_d = lane_seg[idx_q];
        dp_n_d  = ~dpr_q[idx_q];
        an_n_d  = ~(AN_ONE << idx_q);
      end else begin
        seg_n_d = seg_n_q;
        dp_n_d  = dp_n_q;
        an_n_d  = an_n_q;
      end
    end
  end

  // Prescaler restarts on every DRIVE entry, otherwise holds outside DRIVE.
  // Index advances on the DRIVE->GAP edge only.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (state_d == DRIVE) begin
      presc_d = (state_q == DRIVE) ? presc_q + 1'b1 : '0;
    end
    if (state_q == DRIVE && state_d == GAP) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      dig_q     <= '0;
      dpr_q     <= '0;
      invalid_q <= 1'b0;
      seg_n_q   <= 7'h7F;
      dp_n_q    <= 1'b1;
      an_n_q    <= '1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      if (load_strobe) begin
        dig_q <= digits_in;
        dpr_q <= dp_in;
      end
      // Computed from the shadow regs, so it trails the strobe by one edge.
      invalid_q <= |dig_bad;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      an_n_q    <= an_n_d;
    end
  end

  assign seg_n   = seg_n_q;
  assign dp_n    = dp_n_q;
  assign an_n    = an_n_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;
  localparam int ND = 4;
  localparam int RD = 4;

  logic        clock = 1'b0;
  logic        reset, load_strobe, enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n, seg_n_nb;
  logic        dp_n, dp_n_nb;
  logic [3:0]  an_n, an_n_nb;
  logic        invalid, invalid_nb;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bcd_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LEADING(1)) dut (
    .clock(clock), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .load_strobe(load_strobe), .enable(enable),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .invalid(invalid)
  );

  bcd_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LEADING(0)) dut_nb (
    .clock(clock), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .load_strobe(load_strobe), .enable(enable),
    .seg_n(seg_n_nb), .dp_n(dp_n_nb), .an_n(an_n_nb), .invalid(invalid_nb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic dark(input string tag);
    chk({tag, " an"},    an_n,    4'hF);
    chk({tag, " seg"},   seg_n,   7'h7F);
    chk({tag, " dp"},    dp_n,    1'b1);
    chk({tag, " an_nb"}, an_n_nb, 4'hF);
  endtask

  // Walks ncyc cycles of the scan starting on the first DRIVE cycle of digit
  // `start`: 4 driven cycles then 1 dark gap per digit.
  task automatic scan(input string tag, input logic [3:0][6:0] es,
                      input logic [3:0][6:0] es_nb, input logic [3:0] edp,
                      input int start, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int d, p;
      logic [3:0] ea;
      logic [6:0] esg, esg_nb;
      logic       edn;
      d = (start + c / 5) % 4;
      p = c % 5;
      if (p < 4) begin
        ea = ~(4'b0001 << d); esg = es[d]; esg_nb = es_nb[d]; edn = edp[d];
      end else begin
        ea = 4'hF; esg = 7'h7F; esg_nb = 7'h7F; edn = 1'b1;
      end
      chk($sformatf("%s c%0d an", tag, c),     an_n,     ea);
      chk($sformatf("%s c%0d seg", tag, c),    seg_n,    esg);
      chk($sformatf("%s c%0d dp", tag, c),     dp_n,     edn);
      chk($sformatf("%s c%0d an_nb", tag, c),  an_n_nb,  ea);
      chk($sformatf("%s c%0d seg_nb", tag, c), seg_n_nb, esg_nb);
      step(1);
    end
  endtask

  initial begin
    reset = 1'b1; load_strobe = 1'b0; enable = 1'b0; digits_in = '0; dp_in = '0;
    step(2);
    dark("rst");
    chk("rst inv", invalid, 1'b0);

    // Reset mid-DRIVE after loading an invalid code.
    reset = 1'b0; digits_in = 16'h00A5; load_strobe = 1'b1; enable = 1'b1;
    step(1);
    load_strobe = 1'b0;
    chk("inv edgeN", invalid, 1'b0);
    chk("drive an", an_n, 4'hE);
    step(1);
    chk("inv edgeN1", invalid, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    dark("rst mid");
    chk("rst mid inv", invalid, 1'b0);
    step(1);
    chk("shadow0 an", an_n, 4'hE);
    chk("shadow0 seg", seg_n, 7'h40);
    chk("shadow0 seg_nb", seg_n_nb, 7'h40);
    enable = 1'b0;
    step(1);
    dark("disable");

    // 1234 full scan plus one extra cycle to confirm the 20-cycle period.
    digits_in = 16'h1234; load_strobe = 1'b1;
    step(1);
    load_strobe = 1'b0; enable = 1'b1;
    step(1);
    scan("s1234", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 0, 21);

    // 0070: leading-zero blanking vs. all digits shown.
    enable = 1'b0;
    step(1);
    digits_in = 16'h0070; load_strobe = 1'b1;
    step(1);
    load_strobe = 1'b0; enable = 1'b1;
    step(1);
    scan("s0070", {7'h7F, 7'h7F, 7'h78, 7'h40}, {7'h40, 7'h40, 7'h78, 7'h40}, 4'hF, 0, 20);
    chk("s0070 inv", invalid, 1'b0);

    // 00A5: invalid digit shown blank and flagged.
    enable = 1'b0;
    step(1);
    digits_in = 16'h00A5; load_strobe = 1'b1;
    step(1);
    load_strobe = 1'b0;
    chk("A5 inv N", invalid, 1'b0);
    step(1);
    chk("A5 inv N1", invalid, 1'b1);
    chk("A5 inv_nb", invalid_nb, 1'b1);
    enable = 1'b1;
    step(1);
    scan("s00A5", {7'h7F, 7'h7F, 7'h7F, 7'h12}, {7'h40, 7'h40, 7'h7F, 7'h12}, 4'hF, 0, 20);
    digits_in = 16'h0005; load_strobe = 1'b1;
    step(1);
    load_strobe = 1'b0;
    chk("05 inv N", invalid, 1'b1);
    step(1);
    chk("05 inv N1", invalid, 1'b0);

    // Drop enable during digit 2, resume there with a full slot.
    step(10);
    chk("pre-drop an", an_n, 4'hB);
    enable = 1'b0;
    step(1);
    dark("drop");
    step(10);
    dark("drop hold");
    enable = 1'b1;
    step(1);
    scan("resume", {7'h7F, 7'h7F, 7'h7F, 7'h12}, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 2, 10);

    // Strobe mid-slot of digit 1 does not tear the current digit.
    enable = 1'b0;
    step(1);
    digits_in = 16'h1111; dp_in = 4'b0000; load_strobe = 1'b1;
    step(1);
    load_strobe = 1'b0; enable = 1'b1;
    step(1);
    scan("s1111", {7'h79, 7'h79, 7'h79, 7'h79}, {7'h79, 7'h79, 7'h79, 7'h79}, 4'hF, 0, 7);
    digits_in = 16'h9999; dp_in = 4'b0010; load_strobe = 1'b1;
    step(1);
    load_strobe = 1'b0;
    chk("tear an", an_n, 4'hD);
    chk("tear seg", seg_n, 7'h79);
    chk("tear dp", dp_n, 1'b1);
    step(1);
    dark("tear gap");
    step(1);
    scan("s9999", {7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1101, 2, 20);
    chk("s9999 inv", invalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
